// File: rtl/rvfi_retire_serializer.sv
// Serializes up to two retirements per cycle from a dual-issue core onto a
// single RVFI channel through a circular FIFO and a registered output stage.
module rvfi_retire_serializer #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        resetn,

    // Handshake: ret_ready depends on registered state only. On a rising edge
    // with ret_ready == 1 every slot whose ret_valid bit is set is accepted
    // (slot 0 first); with ret_ready == 0 ret_valid is ignored entirely.
    input  logic [1:0]                  ret_valid,
    output logic                        ret_ready,
    input  logic [1:0][ILEN-1:0]        ret_insn,
    input  logic [1:0][XLEN-1:0]        ret_pc_rdata,
    input  logic [1:0][XLEN-1:0]        ret_pc_wdata,
    input  logic [1:0]                  ret_trap,
    input  logic [1:0]                  ret_halt,
    input  logic [1:0]                  ret_intr,
    input  logic [1:0][4:0]             ret_rs1_addr,
    input  logic [1:0][4:0]             ret_rs2_addr,
    input  logic [1:0][4:0]             ret_rd_addr,
    input  logic [1:0][XLEN-1:0]        ret_rs1_rdata,
    input  logic [1:0][XLEN-1:0]        ret_rs2_rdata,
    input  logic [1:0][XLEN-1:0]        ret_rd_wdata,
    input  logic [1:0][XLEN-1:0]        ret_mem_addr,
    input  logic [1:0][XLEN-1:0]        ret_mem_rdata,
    input  logic [1:0][XLEN-1:0]        ret_mem_wdata,
    input  logic [1:0][XLEN/8-1:0]      ret_mem_rmask,
    input  logic [1:0][XLEN/8-1:0]      ret_mem_wmask,

    output logic                        rvfi_valid,
    output logic [63:0]                 rvfi_order,
    output logic [ILEN-1:0]             rvfi_insn,
    output logic [XLEN-1:0]             rvfi_pc_rdata,
    output logic [XLEN-1:0]             rvfi_pc_wdata,
    output logic                        rvfi_trap,
    output logic                        rvfi_halt,
    output logic                        rvfi_intr,
    output logic [4:0]                  rvfi_rs1_addr,
    output logic [4:0]                  rvfi_rs2_addr,
    output logic [4:0]                  rvfi_rd_addr,
    output logic [XLEN-1:0]             rvfi_rs1_rdata,
    output logic [XLEN-1:0]             rvfi_rs2_rdata,
    output logic [XLEN-1:0]             rvfi_rd_wdata,
    output logic [XLEN-1:0]             rvfi_mem_addr,
    output logic [XLEN-1:0]             rvfi_mem_rdata,
    output logic [XLEN-1:0]             rvfi_mem_wdata,
    output logic [XLEN/8-1:0]           rvfi_mem_rmask,
    output logic [XLEN/8-1:0]           rvfi_mem_wmask
);

    localparam int MW = XLEN / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    typedef struct packed {
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic            trap;
        logic            halt;
        logic            intr;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [XLEN-1:0] rd_wdata;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] mem_wdata;
        logic [MW-1:0]   mem_rmask;
        logic [MW-1:0]   mem_wmask;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          slot_e [2];
    entry_t          head_e;
    entry_t          out_q, out_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, wr_ptr_p1;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, n_push;
    logic            halted_q, halted_d;
    logic            valid_q, valid_d;
    logic [63:0]     order_q, order_d;
    logic [63:0]     next_order_q, next_order_d;
    logic [1:0]      push_en;
    logic            pop;

    assign ret_ready = (count_q <= READY_MAX) && !halted_q;
    assign wr_ptr_p1 = wr_ptr_q + PW'(1);

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            slot_e[s].insn      = ret_insn[s];
            slot_e[s].pc_rdata  = ret_pc_rdata[s];
            slot_e[s].pc_wdata  = ret_pc_wdata[s];
            slot_e[s].trap      = ret_trap[s];
            slot_e[s].halt      = ret_halt[s];
            slot_e[s].intr      = ret_intr[s];
            slot_e[s].rs1_addr  = ret_rs1_addr[s];
            slot_e[s].rs2_addr  = ret_rs2_addr[s];
            slot_e[s].rd_addr   = ret_rd_addr[s];
            slot_e[s].rs1_rdata = ret_rs1_rdata[s];
            slot_e[s].rs2_rdata = ret_rs2_rdata[s];
            slot_e[s].rd_wdata  = ret_rd_wdata[s];
            slot_e[s].mem_addr  = ret_mem_addr[s];
            slot_e[s].mem_rdata = ret_mem_rdata[s];
            slot_e[s].mem_wdata = ret_mem_wdata[s];
            slot_e[s].mem_rmask = ret_mem_rmask[s];
            slot_e[s].mem_wmask = ret_mem_wmask[s];
        end
    end

    // Push side: a halting slot 0 retires alone; the younger slot is dropped.
    always_comb begin
        push_en = ret_ready ? ret_valid : 2'b00;
        if (push_en == 2'b11 && slot_e[0].halt) begin
            push_en = 2'b01;
        end
        mem_d    = mem_q;
        halted_d = halted_q;
        n_push   = '0;
        unique case (push_en)
            2'b01: begin
                mem_d[wr_ptr_q] = slot_e[0];
                halted_d        = halted_q | slot_e[0].halt;
                n_push          = CW'(1);
            end
            2'b10: begin
                mem_d[wr_ptr_q] = slot_e[1];
                halted_d        = halted_q | slot_e[1].halt;
                n_push          = CW'(1);
            end
            2'b11: begin
                mem_d[wr_ptr_q]  = slot_e[0];
                mem_d[wr_ptr_p1] = slot_e[1];
                halted_d         = halted_q | slot_e[0].halt | slot_e[1].halt;
                n_push           = CW'(2);
            end
            default: ;
        endcase
        wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
    end

    // Pop side: sanitizes the head entry into the output register.
    always_comb begin
        pop          = (count_q != '0);
        head_e       = mem_q[rd_ptr_q];
        out_d        = out_q;
        valid_d      = 1'b0;
        order_d      = order_q;
        next_order_d = next_order_q;
        rd_ptr_d     = rd_ptr_q;
        if (pop) begin
            out_d = head_e;
            if (head_e.rs1_addr == 5'd0) out_d.rs1_rdata = '0;
            if (head_e.rs2_addr == 5'd0) out_d.rs2_rdata = '0;
            if (head_e.rd_addr == 5'd0 || head_e.trap) out_d.rd_wdata = '0;
            if (head_e.trap) begin
                out_d.rd_addr   = '0;
                out_d.mem_wmask = '0;
            end
            valid_d      = 1'b1;
            order_d      = next_order_q;
            next_order_d = next_order_q + 64'd1;
            rd_ptr_d     = rd_ptr_q + PW'(1);
        end
        count_d = count_q + n_push - CW'(pop);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            halted_q     <= 1'b0;
            valid_q      <= 1'b0;
            order_q      <= '0;
            next_order_q <= '0;
            out_q        <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            halted_q     <= halted_d;
            valid_q      <= valid_d;
            order_q      <= order_d;
            next_order_q <= next_order_d;
            out_q        <= out_d;
        end
    end

    assign rvfi_valid     = valid_q;
    assign rvfi_order     = order_q;
    assign rvfi_insn      = out_q.insn;
    assign rvfi_pc_rdata  = out_q.pc_rdata;
    assign rvfi_pc_wdata  = out_q.pc_wdata;
    assign rvfi_trap      = out_q.trap;
    assign rvfi_halt      = out_q.halt;
    assign rvfi_intr      = out_q.intr;
    assign rvfi_rs1_addr  = out_q.rs1_addr;
    assign rvfi_rs2_addr  = out_q.rs2_addr;
    assign rvfi_rd_addr   = out_q.rd_addr;
    assign rvfi_rs1_rdata = out_q.rs1_rdata;
    assign rvfi_rs2_rdata = out_q.rs2_rdata;
    assign rvfi_rd_wdata  = out_q.rd_wdata;
    assign rvfi_mem_addr  = out_q.mem_addr;
    assign rvfi_mem_rdata = out_q.mem_rdata;
    assign rvfi_mem_wdata = out_q.mem_wdata;
    assign rvfi_mem_rmask = out_q.mem_rmask;
    assign rvfi_mem_wmask = out_q.mem_wmask;

endmodule
